// File: rtl/rv32i_types.sv
// Shared RV32I type definitions: word/register aliases, opcodes and
// the stage-register payload structs used by ID/EX and EX/MEM.
package rv32i_types;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNCT3_W  = 3;

  typedef logic [XLEN-1:0]      rv32i_word;
  typedef logic [REG_IDX_W-1:0] rv32i_reg;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } rv32i_opcode;

  // Opcode is kept as raw bits so undecoded encodings pass through untouched.
  typedef struct packed {
    logic                valid;
    logic                load_reg;
    logic                mem_read;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    rv32i_reg            rd;
    rv32i_reg            rs1;
    rv32i_reg            rs2;
  } idex_ctrl_t;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word rs1_data;
    rv32i_word rs2_data;
    rv32i_word imm;
  } idex_data_t;

endpackage

// File: rtl/load_use_detector.sv
// Flags a consumer in ID that reads the destination of a load sitting one
// stage ahead; x0 destinations never count.
module load_use_detector
  import rv32i_types::*;
(
  input  logic     id_valid,
  input  rv32i_reg id_rs1,
  input  rv32i_reg id_rs2,
  input  logic     id_uses_rs1,
  input  logic     id_uses_rs2,
  input  logic     ex_valid,
  input  logic     ex_mem_read,
  input  rv32i_reg ex_rd,
  output logic     haz_c
);

  logic rs1_match_c;
  logic rs2_match_c;
  logic producer_c;

  always_comb begin
    rs1_match_c = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_match_c = id_uses_rs2 && (id_rs2 == ex_rd);
    producer_c  = ex_valid && ex_mem_read && (ex_rd != '0);
    haz_c       = id_valid && producer_c && (rs1_match_c || rs2_match_c);
  end

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use bubble injection, flush squashing
// and saturating bubble/flush performance counters.
module idex_stage_reg
  import rv32i_types::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_global,
  input  logic                 flush,
  input  logic                 id_valid,
  input  rv32i_word            id_pc,
  input  rv32i_word            id_rs1_data,
  input  rv32i_word            id_rs2_data,
  input  rv32i_word            id_imm,
  input  rv32i_reg             id_rs1,
  input  rv32i_reg             id_rs2,
  input  rv32i_reg             id_rd,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [OPCODE_W-1:0]  id_opcode,
  input  logic [FUNCT3_W-1:0]  id_funct3,
  input  logic                 id_load_reg,
  input  logic                 id_mem_read,
  output logic                 hazard_stall,
  output logic                 idex_valid,
  output logic                 idex_load_reg,
  output logic                 idex_mem_read,
  output rv32i_word            idex_pc,
  output rv32i_word            idex_rs1_data,
  output rv32i_word            idex_rs2_data,
  output rv32i_word            idex_imm,
  output rv32i_reg             idex_rs1,
  output rv32i_reg             idex_rs2,
  output rv32i_reg             idex_rd,
  output logic [OPCODE_W-1:0]  idex_opcode,
  output logic [FUNCT3_W-1:0]  idex_funct3,
  output logic [CNT_WIDTH-1:0] bubble_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  idex_ctrl_t            ctrl_q,   ctrl_d;
  idex_data_t            data_q,   data_d;
  logic [CNT_WIDTH-1:0]  bubble_q, bubble_d;
  logic [CNT_WIDTH-1:0]  flush_q,  flush_d;
  logic                  haz_c;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  load_use_detector u_load_use_detector (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (ctrl_q.valid),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (ctrl_q.rd),
    .haz_c       (haz_c)
  );

  // A flush squashes the consumer anyway, so it must not also freeze IF/ID.
  assign hazard_stall = haz_c && !flush;

  // Next-state selection: global stall > flush > load-use bubble > capture.
  always_comb begin
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    bubble_d = bubble_q;
    flush_d  = flush_q;
    if (!stall_global) begin
      if (flush) begin
        ctrl_d  = '0;
        data_d  = '0;
        flush_d = sat_inc(flush_q);
      end else if (haz_c) begin
        ctrl_d   = '0;
        data_d   = '0;
        bubble_d = sat_inc(bubble_q);
      end else begin
        ctrl_d.valid    = id_valid;
        ctrl_d.load_reg = id_valid && id_load_reg;
        ctrl_d.mem_read = id_valid && id_mem_read;
        ctrl_d.opcode   = id_opcode;
        ctrl_d.funct3   = id_funct3;
        ctrl_d.rd       = id_rd;
        ctrl_d.rs1      = id_rs1;
        ctrl_d.rs2      = id_rs2;
        data_d.pc       = id_pc;
        data_d.rs1_data = id_rs1_data;
        data_d.rs2_data = id_rs2_data;
        data_d.imm      = id_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= '0;
      data_q   <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign idex_valid    = ctrl_q.valid;
  assign idex_load_reg = ctrl_q.load_reg;
  assign idex_mem_read = ctrl_q.mem_read;
  assign idex_opcode   = ctrl_q.opcode;
  assign idex_funct3   = ctrl_q.funct3;
  assign idex_rd       = ctrl_q.rd;
  assign idex_rs1      = ctrl_q.rs1;
  assign idex_rs2      = ctrl_q.rs2;
  assign idex_pc       = data_q.pc;
  assign idex_rs1_data = data_q.rs1_data;
  assign idex_rs2_data = data_q.rs2_data;
  assign idex_imm      = data_q.imm;
  assign bubble_count  = bubble_q;
  assign flush_count   = flush_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: directed load-use/flush/stall/saturation cases
// plus randomized traffic checked every cycle against a behavioural model.
module tb_idex_stage_reg;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;
  localparam logic [6:0]  LOAD = 7'b0000011;
  localparam logic [6:0]  OPR  = 7'b0110011;
  localparam logic [6:0]  OPI  = 7'b0010011;
  localparam logic [6:0]  LUI  = 7'b0110111;

  logic        clk, rst, stall_global, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_load_reg, id_mem_read;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;

  logic          hazard_stall, idex_valid, idex_load_reg, idex_mem_read;
  logic [31:0]   idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
  logic [4:0]    idex_rs1, idex_rs2, idex_rd;
  logic [6:0]    idex_opcode;
  logic [2:0]    idex_funct3;
  logic [CW-1:0] bubble_count, flush_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of what sits in EX, plus event tallies.
  logic        m_valid, m_load_reg, m_mem_read;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [6:0]  m_op;
  logic [2:0]  m_f3;
  int          m_bub, m_flu;

  idex_stage_reg #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall_global(stall_global), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_load_reg(id_load_reg), .id_mem_read(id_mem_read),
    .hazard_stall(hazard_stall), .idex_valid(idex_valid),
    .idex_load_reg(idex_load_reg), .idex_mem_read(idex_mem_read),
    .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data),
    .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm), .idex_rs1(idex_rs1),
    .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_opcode(idex_opcode),
    .idex_funct3(idex_funct3), .bubble_count(bubble_count),
    .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic model_haz();
    return id_valid && m_valid && m_mem_read && (m_rd != 5'd0) &&
           ((id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd));
  endfunction

  task automatic m_empty();
    {m_valid, m_load_reg, m_mem_read} = 3'b000;
    {m_pc, m_rs1d, m_rs2d, m_imm} = '0;
    {m_rs1, m_rs2, m_rd, m_op, m_f3} = '0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_empty();
      m_bub = 0;
      m_flu = 0;
    end else if (!stall_global) begin
      if (flush) begin
        m_empty();
        m_flu = (m_flu < CMAX) ? m_flu + 1 : CMAX;
      end else if (model_haz()) begin
        m_empty();
        m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
      end else begin
        m_valid = id_valid;
        m_load_reg = id_valid & id_load_reg;
        m_mem_read = id_valid & id_mem_read;
        m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
        m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_op = id_opcode; m_f3 = id_funct3;
      end
    end
  end

  always @(negedge clk) begin
    chk("hazard_stall", 32'(hazard_stall), 32'(model_haz() & ~flush));
    chk("valid",    32'(idex_valid),    32'(m_valid));
    chk("load_reg", 32'(idex_load_reg), 32'(m_load_reg));
    chk("mem_read", 32'(idex_mem_read), 32'(m_mem_read));
    chk("pc",       idex_pc,            m_pc);
    chk("rs1_data", idex_rs1_data,      m_rs1d);
    chk("rs2_data", idex_rs2_data,      m_rs2d);
    chk("imm",      idex_imm,           m_imm);
    chk("rs1",      32'(idex_rs1),      32'(m_rs1));
    chk("rs2",      32'(idex_rs2),      32'(m_rs2));
    chk("rd",       32'(idex_rd),       32'(m_rd));
    chk("opcode",   32'(idex_opcode),   32'(m_op));
    chk("funct3",   32'(idex_funct3),   32'(m_f3));
    chk("bubble_count", 32'(bubble_count), 32'(m_bub));
    chk("flush_count",  32'(flush_count),  32'(m_flu));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                           input logic u2, input logic [6:0] op, input logic [2:0] f3,
                           input logic ld, input logic mr);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_opcode = op; id_funct3 = f3;
    id_load_reg = ld; id_mem_read = mr;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
  endtask

  task automatic rand_instr();
    set_instr($urandom_range(0, 99) < 85, $urandom, 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              7'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 99) < 50);
  endtask

  initial begin
    rst = 1'b0; stall_global = 1'b0; flush = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b1;

    // lw x5,0(x1) followed by add x6,x5,x2
    set_instr(1, 32'h40, 5'd1, 5'd0, 5'd5, 1, 0, LOAD, 3'd2, 1, 1);
    tick();
    set_instr(1, 32'h44, 5'd5, 5'd2, 5'd6, 1, 1, OPR, 3'd0, 1, 0);
    at_neg(); chk("lu_stall", 32'(hazard_stall), 32'd1);
    tick();
    at_neg();
    chk("lu_bubble_valid", 32'(idex_valid), 32'd0);
    chk("lu_bubble_cnt", 32'(bubble_count), 32'd1);
    chk("lu_stall_clear", 32'(hazard_stall), 32'd0);
    tick();
    at_neg();
    chk("lu_add_rd", 32'(idex_rd), 32'd6);
    chk("lu_add_valid", 32'(idex_valid), 32'd1);

    // asynchronous reset with a valid instruction in EX
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("rst_valid", 32'(idex_valid), 32'd0);
    chk("rst_rd", 32'(idex_rd), 32'd0);
    chk("rst_pc", idex_pc, 32'd0);
    chk("rst_bubble", 32'(bubble_count), 32'd0);
    chk("rst_stall", 32'(hazard_stall), 32'd0);
    at_neg(); #1 rst = 1'b1;

    // lw x0 then add x6,x0,x2: x0 never hazards
    tick();
    set_instr(1, 32'h80, 5'd1, 5'd0, 5'd0, 1, 0, LOAD, 3'd2, 1, 1);
    tick();
    set_instr(1, 32'h84, 5'd0, 5'd2, 5'd6, 1, 1, OPR, 3'd0, 1, 0);
    at_neg(); chk("x0_no_stall", 32'(hazard_stall), 32'd0);

    // lw x5 then lui x5: lui reads no source
    tick();
    set_instr(1, 32'h88, 5'd1, 5'd0, 5'd5, 1, 0, LOAD, 3'd2, 1, 1);
    tick();
    set_instr(1, 32'h8c, 5'd5, 5'd5, 5'd5, 0, 0, LUI, 3'd0, 1, 0);
    at_neg(); chk("lui_no_stall", 32'(hazard_stall), 32'd0);

    // flush coinciding with a load-use pair
    tick();
    set_instr(1, 32'h90, 5'd1, 5'd0, 5'd5, 1, 0, LOAD, 3'd2, 1, 1);
    tick();
    set_instr(1, 32'h94, 5'd5, 5'd2, 5'd6, 1, 1, OPR, 3'd0, 1, 0);
    flush = 1'b1;
    at_neg(); chk("fh_stall", 32'(hazard_stall), 32'd0);
    tick();
    flush = 1'b0;
    at_neg();
    chk("fh_valid", 32'(idex_valid), 32'd0);
    chk("fh_flush_cnt", 32'(flush_count), 32'd1);
    chk("fh_bubble_cnt", 32'(bubble_count), 32'd0);

    // global stall with churning ID inputs and a flush on the 2nd cycle
    set_instr(1, 32'h100, 5'd1, 5'd0, 5'd7, 1, 0, OPI, 3'd0, 1, 0);
    tick();
    stall_global = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_instr();
      flush = (c == 1);
      at_neg();
      chk("gs_pc", idex_pc, 32'h100);
      chk("gs_rd", 32'(idex_rd), 32'd7);
      chk("gs_flush_cnt", 32'(flush_count), 32'd1);
      tick();
    end
    stall_global = 1'b0; flush = 1'b0;
    set_instr(1, 32'h200, 5'd1, 5'd0, 5'd9, 1, 0, OPI, 3'd0, 1, 0);
    tick();
    at_neg(); chk("gs_resume_pc", idex_pc, 32'h200);

    // 17 load-use hazards: lw x5,0(x5) back to back
    set_instr(1, 32'h300, 5'd5, 5'd0, 5'd5, 1, 0, LOAD, 3'd2, 1, 1);
    repeat (34) tick();
    at_neg(); chk("sat_bubble", 32'(bubble_count), 32'd15);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rand_instr();
      flush = $urandom_range(0, 99) < 10;
      stall_global = $urandom_range(0, 99) < 15;
      tick();
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
    end
    flush = 1'b0; stall_global = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    at_neg(); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/idex_stage_reg.md
Name: idex_stage_reg

Overview:
ID/EX pipeline register for the 5-stage RV32I core. Captures decode-stage operands and control each cycle. Detects load-use hazards against the instruction already in EX and injects a bubble for them. Its rd/rs1/rs2/funct3/load_reg outputs feed the EX-stage forwarding logic and the EX/MEM register. It also keeps saturating counters of bubbles and flushes for performance debug.

Parameters:
CNT_WIDTH, 32, width of each saturating performance counter.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
stall_global  in  1  memory-side stall; hold all state
flush  in  1  branch/jump redirect; squash ID instruction into a bubble
id_valid  in  1  ID holds a real instruction
id_pc  in  32  PC of ID instruction
id_rs1_data, id_rs2_data  in  32 each  regfile read data
id_imm  in  32  decoded immediate
id_rs1, id_rs2, id_rd  in  5 each  register indices (rv32i_reg)
id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1 / rs2
id_opcode  in  7  opcode
id_funct3  in  3  funct3
id_load_reg  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
idex_valid, idex_load_reg, idex_mem_read  out  1 each  registered control
idex_pc, idex_rs1_data, idex_rs2_data, idex_imm  out  32 each  registered data
idex_rs1, idex_rs2, idex_rd  out  5 each  registered indices
idex_opcode  out  7; idex_funct3  out  3  registered
bubble_count, flush_count  out  CNT_WIDTH each  saturating counters

Behaviour:
- Reset (rst low, asynchronous): all registered outputs and counters go to 0. Zero state is a bubble (valid=0, load_reg=0, mem_read=0, rd=0). hazard_stall derives only from state and inputs; it reads 0 in reset because idex_valid=0.
- Hazard term: haz = id_valid & idex_valid & idex_mem_read & (idex_rd!=0) & ((id_uses_rs1 & id_rs1==idex_rd) | (id_uses_rs2 & id_rs2==idex_rd)).
- hazard_stall = haz & ~flush. It is asserted independently of stall_global.
- Per-edge update, highest priority first:
  1. stall_global=1: hold every register and both counters. A flush arriving during a stall is ignored; the requester keeps flush asserted until stall_global=0.
  2. flush=1: load a bubble (all fields 0). flush_count += 1.
  3. haz=1: load a bubble; bubble_count += 1. IF/ID holds because hazard_stall is high.
  4. Otherwise: load all id_* fields; idex_valid = id_valid. If id_valid=0, also force load_reg=0 and mem_read=0.
- Load-use latency: exactly one bubble per load-use pair. After the bubble, idex_rd=0, so haz clears and the dependent instruction enters EX on the next edge. The forwarding unit then supplies the load data from WB.
- x0 rule: idex_rd=0 never raises a hazard, and a bubble always carries rd=0, load_reg=0.
- Counters saturate at all-ones and do not wrap.
- Flush and hazard in the same cycle: flush wins. The result is one bubble, flush_count increments, bubble_count does not, and hazard_stall=0.
- Reset mid-stall: the asynchronous reset clears state immediately. The pipeline resumes on the first edge after rst returns high.

Decomposition:
- Shared package rv32i_types (existing) provides rv32i_word, rv32i_reg and the opcode enums.
- Add an idex_ctrl_t packed struct to the shared package: valid, load_reg, mem_read, opcode, funct3, rd, rs1, rs2. Both this block and the EX/MEM register use it.
- One sub-module: load_use_detector, a pure combinational block producing haz. It is reusable by a future MEM-stage stall check.

Test Plan:
1. Reset: rst low mid-stream with idex_valid=1 -> all outputs 0 immediately (asynchronous). hazard_stall=0.
2. Load-use: `lw x5,0(x1)` then `add x6,x5,x2` -> hazard_stall=1 for one cycle, idex_valid=0 bubble, bubble_count=1; the add is in EX the following cycle.
3. No false hazard:
   - `lw x0` then `add x6,x0,x2` -> no stall.
   - `lw x5` then `lui x5` (id_uses_rs1=0) -> no stall.
4. Flush vs hazard: flush=1 in the same cycle as the load-use condition -> hazard_stall=0, bubble, flush_count=1, bubble_count unchanged.
5. Global stall: stall_global=1 for 3 cycles with id_* changing, including flush=1 on the 2nd cycle -> outputs and counters frozen throughout; normal capture resumes when stall_global drops.
6. Saturation: with CNT_WIDTH=4, force 17 hazards -> bubble_count holds at 15.
